// File: rtl/cpu_mem_arbiter.sv
// Round-robin 2:1 arbiter (inst fetch / data) onto one memory port, one transaction outstanding.
// Latency: request appears downstream the cycle after IDLE sees it; req_ready/rready mirror the memory side combinationally.
module cpu_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    output logic [31:0]           inst_rdata,
    output logic                  inst_rvalid,
    input  logic                  inst_rready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_write,
    input  logic                  d_read,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    output logic                  d_req_ready,
    output logic [31:0]           d_rdata,
    output logic                  d_rvalid,
    input  logic                  d_rready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_write,
    output logic                  m_read,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    input  logic                  m_req_ready,
    input  logic [31:0]           m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   last, last_nxt;
    logic   d_req;
    logic   both_req;

    assign d_req    = d_write | d_read;
    assign both_req = inst_req_valid & d_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            if (state == IDLE && both_req)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_nxt       = last;
        inst_req_ready = 1'b0;
        inst_rvalid    = 1'b0;
        d_req_ready    = 1'b0;
        d_rvalid       = 1'b0;
        m_addr         = '0;
        m_write        = 1'b0;
        m_read         = 1'b0;
        m_wdata        = '0;
        m_wstrb        = '0;
        m_rready       = 1'b0;
        inst_rdata     = m_rdata;
        d_rdata        = m_rdata;

        case (state)
            IDLE: begin
                if (inst_req_valid || d_req) begin
                    // On contention the requester not served last wins.
                    grant_nxt = both_req ? ~last : d_req;
                    last_nxt  = grant_nxt;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (grant) begin
                    m_addr      = d_addr;
                    m_write     = d_write;
                    m_read      = d_read & ~d_write;
                    m_wdata     = d_wdata;
                    m_wstrb     = d_wstrb;
                    d_req_ready = m_req_ready;
                end else begin
                    m_addr         = inst_addr;
                    m_read         = 1'b1;
                    inst_req_ready = m_req_ready;
                end
                // Writes complete at the request handshake; reads wait for data.
                if (m_req_ready)
                    state_nxt = (grant && d_write) ? IDLE : RESP;
            end
            RESP: begin
                m_rready = grant ? d_rready : inst_rready;
                if (grant)
                    d_rvalid = m_rvalid;
                else
                    inst_rvalid = m_rvalid;
                if (m_rvalid && m_rready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
